// File: rtl/polar_averager_if.sv
// polar_averager_if
//   AXI-Stream style bundle for the polar sample stream {angle[31:16], radius[15:0]}.
//   Signals: tdata (32), tvalid, tlast, tstrb (4), tready.
//   master: drives tdata/tvalid/tlast/tstrb and receives tready.
//   slave : receives tdata/tvalid/tlast/tstrb and drives tready.
interface polar_averager_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic [3:0]  tstrb;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, output tstrb, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tstrb, output tready);
endinterface

// File: rtl/polar_averager.sv
// polar_averager
//   Averages 2^LOG2_AVG consecutive polar samples into one output beat.
//   Radius is summed unsigned and truncated. Phase is averaged as signed
//   offsets from the first angle of the window, so windows that straddle the
//   0/360 degree seam average correctly.
// Ports:
//   s00_axis_aclk    : sole clock
//   s00_axis_aresetn : asynchronous active-low reset
//   s00_axis         : input stream (slave); tstrb ignored
//   m00_axis         : output stream (master); tlast = OR of window tlasts,
//                      tstrb constant 4'hF
module polar_averager #(
  parameter int LOG2_AVG               = 4,
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
  input  logic              s00_axis_aclk,
  input  logic              s00_axis_aresetn,
  polar_averager_if.slave   s00_axis,
  polar_averager_if.master  m00_axis
);

  localparam int N  = 1 << LOG2_AVG;
  localparam int AW = 16 + LOG2_AVG;

  logic [8:0]           cnt_q,    cnt_d;
  logic [15:0]          ref_q,    ref_d;
  logic signed [AW-1:0] pacc_q,   pacc_d;
  logic [AW-1:0]        racc_q,   racc_d;
  logic                 flag_q,   flag_d;
  logic [31:0]          odata_q,  odata_d;
  logic                 ovalid_q, ovalid_d;
  logic                 olast_q,  olast_d;

  logic                 s_ready_s;
  logic                 accept_s;
  logic                 first_s;
  logic                 last_s;
  logic [15:0]          angle_s;
  logic [15:0]          radius_s;
  logic signed [15:0]   delta_s;
  logic [15:0]          ref_s;
  logic signed [AW-1:0] psum_s;
  logic [AW-1:0]        rsum_s;
  logic                 flag_s;
  logic signed [AW-1:0] pshift_s;
  logic [AW-1:0]        rshift_s;
  logic [15:0]          mean_angle_s;
  logic [15:0]          mean_radius_s;

  // Input may advance whenever the output register is empty or being drained.
  assign s_ready_s       = !ovalid_q || m00_axis.tready;
  assign accept_s        = s00_axis.tvalid && s_ready_s;
  assign s00_axis.tready = s_ready_s;

  assign m00_axis.tdata  = odata_q;
  assign m00_axis.tvalid = ovalid_q;
  assign m00_axis.tlast  = olast_q;
  assign m00_axis.tstrb  = 4'hF;

  // Running sums including the beat currently on the input.
  always_comb begin
    angle_s  = s00_axis.tdata[31:16];
    radius_s = s00_axis.tdata[15:0];
    first_s  = (cnt_q == 9'd0);
    last_s   = (cnt_q == 9'(N - 1));
    // Modular difference reinterpreted as signed gives the shortest-arc offset.
    delta_s  = signed'(angle_s - ref_q);
    if (first_s) begin
      ref_s  = angle_s;
      psum_s = '0;
      rsum_s = AW'(radius_s);
      flag_s = s00_axis.tlast;
    end else begin
      ref_s  = ref_q;
      psum_s = pacc_q + AW'(delta_s);
      rsum_s = racc_q + AW'(radius_s);
      flag_s = flag_q | s00_axis.tlast;
    end
    // Arithmetic shift floors the mean offset; the sum back onto ref wraps mod 2^16.
    pshift_s      = psum_s >>> LOG2_AVG;
    rshift_s      = rsum_s >> LOG2_AVG;
    mean_angle_s  = ref_s + pshift_s[15:0];
    mean_radius_s = rshift_s[15:0];
  end

  // Next-state for window accumulators and the output register.
  always_comb begin
    cnt_d    = cnt_q;
    ref_d    = ref_q;
    pacc_d   = pacc_q;
    racc_d   = racc_q;
    flag_d   = flag_q;
    odata_d  = odata_q;
    olast_d  = olast_q;
    if (m00_axis.tready) begin
      ovalid_d = 1'b0;
    end else begin
      ovalid_d = ovalid_q;
    end
    if (accept_s) begin
      ref_d  = ref_s;
      pacc_d = psum_s;
      racc_d = rsum_s;
      flag_d = flag_s;
      if (last_s) begin
        cnt_d    = 9'd0;
        odata_d  = {mean_angle_s, mean_radius_s};
        olast_d  = flag_s;
        ovalid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 9'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards any partial window.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      cnt_q    <= 9'd0;
      ref_q    <= 16'd0;
      pacc_q   <= '0;
      racc_q   <= '0;
      flag_q   <= 1'b0;
      odata_q  <= 32'd0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      pacc_q   <= pacc_d;
      racc_q   <= racc_d;
      flag_q   <= flag_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
    end
  end

endmodule

// File: tb/tb_polar_averager.sv
// tb_polar_averager
//   Directed bench for polar_averager with LOG2_AVG=2 (4-sample windows).
//   Expected output beats are queued as stimulus is issued; a monitor pops
//   and compares every beat the DUT transfers.
module tb_polar_averager;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [32:0] exp_q[$];

  polar_averager_if s_if ();
  polar_averager_if m_if ();

  polar_averager #(.LOG2_AVG(2)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis         (s_if),
    .m00_axis         (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: a beat transfers at the next rising edge when valid and ready.
  always @(negedge clk) begin
    if (rst_n && m_if.tvalid && m_if.tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected got data=%h last=%b expected none", m_if.tdata, m_if.tlast);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({m_if.tlast, m_if.tdata} !== e) begin
          n_fail++;
          $display("FAIL out_beat got data=%h last=%b expected data=%h last=%b",
                   m_if.tdata, m_if.tlast, e[31:0], e[32]);
        end
      end
    end
  end

  // Drive one beat; returns at rising edge + 1 with the number of cycles taken.
  task automatic send(input logic [15:0] ang, input logic [15:0] rad, input logic lst,
                      output int cyc);
    logic rdy;
    logic done;
    cyc  = 0;
    done = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = {ang, rad};
    s_if.tlast  = lst;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = s_if.tready;
      @(posedge clk);
      cyc++;
      if (rdy) begin
        done = 1'b1;
        break;
      end
    end
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout got=not_accepted expected=accepted");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset pulse between clock edges, starting at rising edge + 1.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    check("rst_tdata", m_if.tdata, 32'd0);
    check("rst_tlast", {31'd0, m_if.tlast}, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    logic [31:0] held;
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 32'd0;
    s_if.tlast  = 1'b0;
    s_if.tstrb  = 4'h0;
    m_if.tready = 1'b1;

    // 1. Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    check("reset_tdata", m_if.tdata, 32'd0);
    check("reset_tlast", {31'd0, m_if.tlast}, 32'd0);
    rst_n = 1'b1;
    idle(1);
    check("reset_s_tready", {31'd0, s_if.tready}, 32'd1);
    check("tstrb_const", {28'd0, m_if.tstrb}, 32'h0000_000F);

    // 2. Radius mean and one-cycle latency
    exp_q.push_back({1'b0, 32'h1000_0065});
    send(16'h1000, 16'd100, 1'b0, c);
    send(16'h1000, 16'd101, 1'b0, c);
    send(16'h1000, 16'd102, 1'b0, c);
    check("no_early_valid", {31'd0, m_if.tvalid}, 32'd0);
    send(16'h1000, 16'd104, 1'b0, c);
    check("latency_valid", {31'd0, m_if.tvalid}, 32'd1);

    // 3. Phase wrap, positive and negative offsets
    exp_q.push_back({1'b0, 32'h0000_0032});
    send(16'hFFF0, 16'd50, 1'b0, c);
    send(16'h0010, 16'd50, 1'b0, c);
    send(16'hFFF0, 16'd50, 1'b0, c);
    send(16'h0010, 16'd50, 1'b0, c);
    exp_q.push_back({1'b0, 32'hFFFD_0032});
    send(16'h0000, 16'd50, 1'b0, c);
    send(16'hFFFC, 16'd50, 1'b0, c);
    send(16'hFFFC, 16'd50, 1'b0, c);
    send(16'hFFFC, 16'd50, 1'b0, c);
    idle(2);

    // 4. Backpressure: output held, input stalled
    m_if.tready = 1'b0;
    exp_q.push_back({1'b0, 32'h2000_0019});
    send(16'h2000, 16'd10, 1'b0, c);
    send(16'h2000, 16'd20, 1'b0, c);
    send(16'h2000, 16'd30, 1'b0, c);
    send(16'h2000, 16'd40, 1'b0, c);
    held = m_if.tdata;
    check("bp_held_value", held, 32'h2000_0019);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_tvalid", {31'd0, m_if.tvalid}, 32'd1);
      check("bp_tdata_stable", m_if.tdata, held);
      check("bp_s_tready", {31'd0, s_if.tready}, 32'd0);
    end
    @(posedge clk);
    #1;
    m_if.tready = 1'b1;
    exp_q.push_back({1'b0, 32'h3000_0002});
    send(16'h3000, 16'd1, 1'b0, c);
    check("bp_resume_cyc0", c, 32'd1);
    send(16'h3000, 16'd2, 1'b0, c);
    check("bp_resume_cyc1", c, 32'd1);
    send(16'h3000, 16'd3, 1'b0, c);
    check("bp_resume_cyc2", c, 32'd1);
    send(16'h3000, 16'd5, 1'b0, c);
    check("bp_resume_cyc3", c, 32'd1);

    // 5. tlast propagates via OR, only in its own window
    exp_q.push_back({1'b1, 32'h4000_0008});
    send(16'h4000, 16'd8, 1'b0, c);
    send(16'h4000, 16'd8, 1'b0, c);
    send(16'h4000, 16'd8, 1'b1, c);
    send(16'h4000, 16'd8, 1'b0, c);
    exp_q.push_back({1'b0, 32'h4000_0010});
    send(16'h4000, 16'd16, 1'b0, c);
    send(16'h4000, 16'd16, 1'b0, c);
    send(16'h4000, 16'd16, 1'b0, c);
    send(16'h4000, 16'd16, 1'b0, c);
    idle(2);

    // 6a. Reset while an output is held: it is discarded
    m_if.tready = 1'b0;
    send(16'h7000, 16'd9, 1'b0, c);
    send(16'h7000, 16'd9, 1'b0, c);
    send(16'h7000, 16'd9, 1'b1, c);
    send(16'h7000, 16'd9, 1'b0, c);
    check("pre_rst_valid", {31'd0, m_if.tvalid}, 32'd1);
    pulse_reset();
    m_if.tready = 1'b1;

    // 6b. Reset mid-window: stale beats excluded from the next window
    send(16'h5000, 16'd1000, 1'b0, c);
    send(16'h5000, 16'd1000, 1'b0, c);
    pulse_reset();
    exp_q.push_back({1'b0, 32'h6000_0004});
    send(16'h6000, 16'd4, 1'b0, c);
    send(16'h6000, 16'd4, 1'b0, c);
    send(16'h6000, 16'd4, 1'b0, c);
    send(16'h6000, 16'd4, 1'b0, c);

    // Drain
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain_pending", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
